// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide unit and the control FSM's funct decode.
package muldiv_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_MUL  = 3'd1;
  localparam logic [2:0] ST_DIV  = 3'd2;
  localparam logic [2:0] ST_FIX  = 3'd3;
  localparam logic [2:0] ST_DZ   = 3'd4;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    MUL  = ST_MUL,
    DIV  = ST_DIV,
    FIX  = ST_FIX,
    DZ   = ST_DZ
  } md_state_t;

  // Bit 1 of the op selects divide; bit 0 clear means signed.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the magnitude datapath. The 2*WIDTH accumulator holds
// {partial product, remaining multiplier bits} for multiply and
// {partial remainder, remaining dividend / quotient bits} for divide.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Shift-add for multiply, restore-subtract for divide.
  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    shifted  = acc[2*WIDTH-1:WIDTH-1];
    diff     = shifted - {1'b0, opnd};
    acc_next = {sum, acc[WIDTH-1:1]};
    if (is_div) begin
      // A negative trial difference means the divisor did not fit: keep the
      // shifted remainder and shift in a 0 quotient bit.
      if (diff[WIDTH]) acc_next = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else             acc_next = {diff[WIDTH-1:0],    acc[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative mult/multu/div/divu unit with HI/LO registers. One bit per cycle
// on unsigned magnitudes, signs restored in a single FIX cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_t          state;
  logic               div_r;
  logic               sq;
  logic               sr;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;

  logic               sgn;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Operand magnitudes at start; the most-negative value maps to itself,
  // which is its correct unsigned magnitude.
  assign sgn   = op_is_signed(op);
  assign abs_a = (sgn && a[WIDTH-1]) ? -a : a;
  assign abs_b = (sgn && b[WIDTH-1]) ? -b : b;

  // Sign fix-up applied on the FIX edge; the remainder follows the dividend.
  assign prod_fix = sq ? -acc : acc;
  assign quo_fix  = sq ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = sr ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (state == DIV),
    .acc      (acc),
    .opnd     (opnd),
    .acc_next (acc_next)
  );

  // Control FSM, iteration counter and HI/LO registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      div_r       <= 1'b0;
      sq          <= 1'b0;
      sr          <= 1'b0;
      cnt         <= '0;
      acc         <= '0;
      opnd        <= '0;
      hi          <= '0;
      lo          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            div_r <= op_is_div(op);
            sq    <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
            sr    <= sgn & a[WIDTH-1];
            cnt   <= '0;
            busy  <= 1'b1;
            if (op_is_div(op) && b == '0) begin
              // Raw dividend parked in the accumulator for the DZ write.
              acc   <= {{WIDTH{1'b0}}, a};
              state <= DZ;
            end else if (op_is_div(op)) begin
              acc   <= {{WIDTH{1'b0}}, abs_a};
              opnd  <= abs_b;
              state <= DIV;
            end else begin
              acc   <= {{WIDTH{1'b0}}, abs_b};
              opnd  <= abs_a;
              state <= MUL;
            end
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        MUL, DIV: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH-1)) state <= FIX;
        end
        FIX: begin
          if (div_r) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        DZ: begin
          hi          <= acc[WIDTH-1:0];
          lo          <= '1;
          busy        <= 1'b0;
          done        <= 1'b1;
          div_by_zero <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit at WIDTH=32 and WIDTH=8.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start, hi_we, lo_we, busy, done, dz;
  logic [1:0]  op;
  logic [31:0] a, b, wdata, hi, lo;

  logic        start8, hi_we8, lo_we8, busy8, done8, dz8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, wdata8, hi8, lo8;

  muldiv_unit #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
    .div_by_zero(dz), .hi(hi), .lo(lo)
  );

  muldiv_unit #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
    .hi_we(hi_we8), .lo_we(lo_we8), .wdata(wdata8), .busy(busy8), .done(done8),
    .div_by_zero(dz8), .hi(hi8), .lo(lo8)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference: plain 64-bit arithmetic; SV signed / and % truncate toward zero
  // with the remainder taking the dividend's sign.
  task automatic model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] h, output logic [31:0] l, output logic z);
    logic signed [63:0] sx, sy, sp, sqt, srm;
    logic [63:0] ux, uy, up, ur;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'b0, x};
    uy = {32'b0, y};
    z  = 1'b0;
    if (o == MD_MULT) begin
      sp = sx * sy; {h, l} = sp;
    end else if (o == MD_MULTU) begin
      up = ux * uy; {h, l} = up;
    end else if (y == 32'd0) begin
      h = x; l = 32'hFFFFFFFF; z = 1'b1;
    end else if (o == MD_DIV) begin
      sqt = sx / sy; srm = sx % sy;
      l = sqt[31:0]; h = srm[31:0];
    end else begin
      up = ux / uy; ur = ux % uy;
      l = up[31:0]; h = ur[31:0];
    end
  endtask

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic run32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int lat, output int bc, output logic [31:0] h,
                       output logic [31:0] l, output logic z);
    start = 1'b1; op = o; a = x; b = y;
    lat = 0; bc = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      if (busy) bc++;
      if (done) begin lat = i; break; end
    end
    h = hi; l = lo; z = dz;
  endtask

  task automatic run8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                      output int lat, output logic [7:0] h, output logic [7:0] l);
    start8 = 1'b1; op8 = o; a8 = x; b8 = y;
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1 start8 = 1'b0;
      @(negedge clk);
      if (done8) begin lat = i; break; end
    end
    h = hi8; l = lo8;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vt[8];

  initial begin
    int lat, bc;
    logic [31:0] h, l, eh, el, x, y;
    logic [7:0] h8, l8;
    logic z, ez;
    logic [1:0] o;

    vt[0] = '{MD_MULT,  32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34};
    vt[1] = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34};
    vt[2] = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34};
    vt[3] = '{MD_DIVU,  32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, 1'b1, 2};
    vt[4] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34};
    vt[5] = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 34};
    vt[6] = '{MD_DIV,   32'd0,        32'd0,        32'h00000000, 32'hFFFFFFFF, 1'b1, 2};
    vt[7] = '{MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 34};

    start = 0; op = 0; a = 0; b = 0; hi_we = 0; lo_we = 0; wdata = 0;
    start8 = 0; op8 = 0; a8 = 0; b8 = 0; hi_we8 = 0; lo_we8 = 0; wdata8 = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_hi", hi, 0); chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_dz", dz, 0);
    chk("rst_hi8", hi8, 0); chk("rst_lo8", lo8, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed table
    foreach (vt[i]) begin
      run32(vt[i].op, vt[i].a, vt[i].b, lat, bc, h, l, z);
      chk($sformatf("v%0d_lat", i), lat, vt[i].lat);
      chk($sformatf("v%0d_busy", i), bc, vt[i].lat - 1);
      chk($sformatf("v%0d_hi", i), h, vt[i].hi);
      chk($sformatf("v%0d_lo", i), l, vt[i].lo);
      chk($sformatf("v%0d_dz", i), z, vt[i].dz);
      @(negedge clk);
      chk($sformatf("v%0d_pulse", i), {done, dz}, 2'b00);
    end

    // Random against the reference model
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 7) == 0) y = 32'd0;
      else if ($urandom_range(0, 3) == 0) y = 32'($urandom_range(1, 20)) * (($urandom_range(0, 1) == 1) ? -32'sd1 : 32'sd1);
      model(o, x, y, eh, el, ez);
      run32(o, x, y, lat, bc, h, l, z);
      chk($sformatf("r%0d_lat", i), lat, ez ? 2 : 34);
      chk($sformatf("r%0d_hi", i), h, eh);
      chk($sformatf("r%0d_lo", i), l, el);
      chk($sformatf("r%0d_dz", i), z, ez);
      @(negedge clk);
    end

    // Back-to-back: new start sampled in the done cycle
    run32(MD_MULT, 32'd3, 32'd4, lat, bc, h, l, z);
    run32(MD_MULTU, 32'd5, 32'd6, lat, bc, h, l, z);
    chk("b2b_lat", lat, 34); chk("b2b_lo", l, 30); chk("b2b_hi", h, 0);
    @(negedge clk);

    // mthi / mtlo / both
    hi_we = 1; wdata = 32'hA5A5A5A5;
    @(posedge clk); #1 hi_we = 0;
    chk("mthi_hi", hi, 32'hA5A5A5A5); chk("mthi_lo", lo, 32'd30);
    @(negedge clk);
    lo_we = 1; wdata = 32'h5A5A5A5A;
    @(posedge clk); #1 lo_we = 0;
    chk("mtlo_lo", lo, 32'h5A5A5A5A); chk("mtlo_hi", hi, 32'hA5A5A5A5);
    @(negedge clk);
    hi_we = 1; lo_we = 1; wdata = 32'hC3C3C3C3;
    @(posedge clk); #1 hi_we = 0; lo_we = 0;
    chk("mtboth", {hi, lo}, {2{32'hC3C3C3C3}});
    @(negedge clk);

    // start and hi_we in the same IDLE cycle: start wins
    start = 1; op = MD_MULTU; a = 32'd2; b = 32'd3; hi_we = 1; wdata = 32'hDEADBEEF;
    @(posedge clk); #1 start = 0; hi_we = 0;
    chk("sw_hi_kept", hi, 32'hC3C3C3C3);
    lat = 0;
    for (int i = 2; i <= 100; i++) begin
      @(negedge clk);
      if (done) begin lat = i - 1; break; end
      @(posedge clk);
    end
    chk("sw_lat", lat, 34); chk("sw_res", {hi, lo}, 64'd6);
    @(negedge clk);

    // Disturbances while busy, including the FIX edge, are ignored
    start = 1; op = MD_MULT; a = 32'd100; b = 32'hFFFFFFFE;
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (i < 6 || i == 33) begin
        start = 1; op = MD_MULTU; a = 32'd3; b = 32'd3;
        hi_we = 1; lo_we = 1; wdata = 32'h12345678;
      end else begin
        start = 0; hi_we = 0; lo_we = 0;
      end
      @(negedge clk);
      if (done) begin lat = i; break; end
    end
    start = 0; hi_we = 0; lo_we = 0;
    chk("dist_lat", lat, 34);
    chk("dist_hi", hi, 32'hFFFFFFFF); chk("dist_lo", lo, 32'hFFFFFF38);
    @(negedge clk);
    chk("dist_idle", busy, 0);

    // Async reset in the middle of a divide
    start = 1; op = MD_DIV; a = 32'd1000; b = 32'd7;
    @(posedge clk); #1 start = 0;
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mrst_hi", hi, 0); chk("mrst_lo", lo, 0);
    chk("mrst_busy", busy, 0); chk("mrst_done", done, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    run32(MD_MULT, 32'd7, 32'hFFFFFFFD, lat, bc, h, l, z);
    chk("post_rst_lat", lat, 34);
    chk("post_rst_res", {h, l}, 64'hFFFFFFFF_FFFFFFEB);
    @(negedge clk);

    // WIDTH=8 instance
    run8(MD_MULT, 8'h80, 8'h80, lat, h8, l8);
    chk("w8_mul_lat", lat, 10); chk("w8_mul", {h8, l8}, 16'h4000);
    @(negedge clk);
    run8(MD_DIVU, 8'hFF, 8'h10, lat, h8, l8);
    chk("w8_divu_lat", lat, 10); chk("w8_divu", {h8, l8}, 16'h0F0F);
    @(negedge clk);
    run8(MD_DIV, 8'h80, 8'hFF, lat, h8, l8);
    chk("w8_ovf", {h8, l8}, 16'h0080);
    @(negedge clk);
    run8(MD_DIV, 8'h33, 8'h00, lat, h8, l8);
    chk("w8_dz_lat", lat, 2); chk("w8_dz", {h8, l8, dz8}, {8'h33, 8'hFF, 1'b1});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Parametrised iterative multiply/divide unit with HI/LO registers for the multi-cycle MIPS core. It executes mult, multu, div and divu one bit per cycle, with a start/busy/done handshake to the control FSM. It also accepts mthi/mtlo writes. It sits beside the ALU: operands come from the A/B operand registers, and the hi/lo outputs feed the writeback mux for mfhi/mflo.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits; must be >= 4
CNT_W, $clog2(WIDTH+1), iteration counter width; derived, not overridden

Ports:
clk  input  1  clock; all state changes on the rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  begin an operation; sampled only in IDLE
op  input  2  00 mult, 01 multu, 10 div, 11 divu; sampled with start
a  input  WIDTH  multiplicand / dividend; sampled with start
b  input  WIDTH  multiplier / divisor; sampled with start
hi_we  input  1  mthi write strobe
lo_we  input  1  mtlo write strobe
wdata  input  WIDTH  data for mthi/mtlo
busy  output  1  operation in progress
done  output  1  one-cycle pulse; hi/lo hold the new result
div_by_zero  output  1  pulses with done when a div/divu had b==0
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (asynchronous, any state including mid-operation): state=IDLE; hi=lo=0; busy=done=div_by_zero=0; counter and working registers cleared. No partial result survives reset.
- States: IDLE, MUL, DIV, FIX, DZ.
- IDLE, start=1 on edge k:
  - latch op and operands;
  - for signed ops, latch absolute values plus the sign flags sq=a[msb]^b[msb] and sr=a[msb];
  - move to MUL or DIV, or to DZ if the op is div/divu and b==0;
  - busy=1 from edge k onward.
- MUL: shift-add of unsigned magnitudes, 2*WIDTH-bit accumulator, WIDTH iterations on edges k+1..k+WIDTH, then go to FIX.
- DIV: restoring division of magnitudes, one quotient bit per edge, WIDTH iterations on edges k+1..k+WIDTH, then go to FIX.
- FIX (edge k+WIDTH+1):
  - mult: negate the 2*WIDTH product if sq.
  - div: negate the quotient if sq; negate the remainder if sr (the remainder takes the dividend's sign).
  - Write {hi,lo} = product, or hi=remainder, lo=quotient.
  - Go to IDLE; done=1 and busy=0 for exactly the following cycle.
- Total latency: done is visible WIDTH+2 cycles after start is sampled (34 cycles at WIDTH=32).
- DZ (edge k+1): hi=a as sampled, lo=all ones, div_by_zero=1 and done=1 for the following cycle; go to IDLE. Latency is 2 cycles.
- Signed overflow (most-negative / -1) is not special-cased: lo=most-negative, hi=0. This falls out of the magnitude-and-fix algorithm.
- The multiply result is full-width 2*WIDTH; no overflow flag.
- start while busy: ignored. No queuing, no error output.
- hi_we/lo_we:
  - applied in IDLE only, effective the next edge;
  - ignored while busy, and ignored on the FIX and DZ edges;
  - hi_we and lo_we together write both registers.
- start and hi_we/lo_we in the same IDLE cycle: start wins and the write is dropped.
- done and div_by_zero are registered; both are 0 in every cycle other than the single result cycle.
- A new start may be sampled in the same cycle that done=1, because the state is already IDLE.
- hi/lo change only on the FIX edge, the DZ edge, accepted mthi/mtlo writes, and reset. Reads are combinational from the registers.

Decomposition:
- Shared package muldiv_pkg holds:
  - op encodings: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU;
  - the state encoding (IDLE, MUL, DIV, FIX, DZ) as 3-bit localparams.
- The control FSM's funct decoding uses the same package.
- Optional sub-module muldiv_step: combinational single-iteration shift-add / restore-subtract datapath. The FSM, counter and HI/LO registers stay in muldiv_unit.

Test Plan:
- WIDTH=32, mult a=7 b=32'hFFFFFFFD (-3) -> done exactly 34 cycles after start; hi=32'hFFFFFFFF, lo=32'hFFFFFFEB; busy high for 33 cycles.
- multu a=b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001. Then div a=-7 b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
- divu a=32'h1234 b=0 -> done and div_by_zero pulse 2 cycles after start; hi=32'h1234, lo=32'hFFFFFFFF. Next, div 32'h80000000 / -1 -> lo=32'h80000000, hi=0, div_by_zero=0.
- mthi 32'hA5A5A5A5 in IDLE -> hi updates next edge. Then start mult, and assert hi_we, lo_we and start during busy -> all ignored; result matches the first operation only.
- Assert rst at cycle 10 of a div -> hi=lo=0 and busy=0 immediately (async). A start after release completes normally in 34 cycles.
- WIDTH=8 instance: mult 8'h80 * 8'h80 -> done 10 cycles after start, hi=8'h40, lo=8'h00. divu 8'hFF / 8'h10 -> lo=8'h0F, hi=8'h0F.
